// File: rtl/shared_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_ram_pkg
// Purpose  : Shared types, limits and helper functions for multiport_shared_ram.
// Revision : 1.0 - initial release
// ============================================================================
package shared_ram_pkg;

    localparam int MAX_PORTS  = 8;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_LANES  = MAX_DATA_W / 8;

    function automatic int clog2_safe(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [clog2_safe(MAX_PORTS)-1:0] port_id_t;

    // Even parity per byte lane; callers keep the low DATA_W/8 bits.
    function automatic logic [MAX_LANES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
        logic [MAX_LANES-1:0] par;
        for (int b = 0; b < MAX_LANES; b++) begin
            par[b] = ^data[b*8 +: 8];
        end
        return par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiport_shared_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter, one-hot grant, pointer moves only on a grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import shared_ram_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              advance,
    output logic [NPORTS-1:0] grant
);

    localparam int c_ptr_w = clog2_safe(NPORTS);

    logic [c_ptr_w-1:0] r_ptr;
    int                 w_win;
    int                 w_best;
    logic               w_any;

    // Winner is the requester with the smallest circular distance from r_ptr.
    always_comb begin
        w_win  = 0;
        w_best = NPORTS;
        w_any  = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            if (req[j] && (((j + NPORTS - int'(r_ptr)) % NPORTS) < w_best)) begin
                w_best = (j + NPORTS - int'(r_ptr)) % NPORTS;
                w_win  = j;
                w_any  = advance;
            end
        end
    end

    for (genvar j = 0; j < NPORTS; j++) begin : g_grant
        assign grant[j] = w_any && (w_win == j);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= c_ptr_w'((w_win + 1) % NPORTS);
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiport_shared_ram.sv
`default_nettype none
// ============================================================================
// Module   : multiport_shared_ram
// Purpose  : N-port Avalon-MM shared RAM, round-robin arbitrated single-port array.
//            Optional byte parity when SHARED_RAM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_shared_ram
    import shared_ram_pkg::*;
#(
    parameter int    NPORTS       = 4,
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 16384,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "Core4_onchip_shared.hex",
    localparam int   ADDR_W       = clog2_safe(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_req,
    input  logic [NPORTS-1:0]            chipselect,
    input  logic [NPORTS-1:0]            read,
    input  logic [NPORTS-1:0]            write,
    input  logic [NPORTS*ADDR_W-1:0]     address,
    input  logic [NPORTS*DATA_W/8-1:0]   byteenable,
    input  logic [NPORTS*DATA_W-1:0]     writedata,
    output logic [NPORTS-1:0]            waitrequest,
    output logic [NPORTS*DATA_W-1:0]     readdata,
    output logic [NPORTS-1:0]            readdatavalid,
    output logic [NPORTS-1:0]            parity_err
);

    localparam int c_lanes = DATA_W / 8;

    logic [NPORTS-1:0]  w_req;
    logic [NPORTS-1:0]  w_grant;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [c_lanes-1:0] w_be;
    logic               w_wr;
    logic               w_rd;
    port_id_t           w_sel;
    logic               w_in_range;
    logic               w_wr_go;
    logic               w_perr_raw;
    logic [DATA_W-1:0]  w_out_data;
    logic               w_out_perr;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DATA_W-1:0]       r_rd_data;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    port_id_t                r_pipe_id [READ_LATENCY];

    assign w_req = chipselect & (read | write);

    rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .advance (~reset_req & ~reset),
        .grant   (w_grant)
    );

    assign waitrequest = w_req & ~w_grant;

    // Read+write together on the winning port is a write.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_sel   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_grant[p]) begin
                w_addr  = address[p*ADDR_W +: ADDR_W];
                w_wdata = writedata[p*DATA_W +: DATA_W];
                w_be    = byteenable[p*c_lanes +: c_lanes];
                w_wr    = write[p];
                w_rd    = read[p] & ~write[p];
                w_sel   = port_id_t'(p);
            end
        end
    end

    assign w_in_range = 32'(w_addr) < 32'(DEPTH);
    assign w_wr_go    = w_wr & w_in_range;

    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (w_be[b]) begin
                    r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd) begin
            r_rd_data <= w_in_range ? r_mem[w_addr] : '0;
        end
    end

`ifdef SHARED_RAM_PARITY_EN
    logic [c_lanes-1:0]   r_par [DEPTH];
    logic [c_lanes-1:0]   r_rd_par;
    logic [MAX_LANES-1:0] w_wr_par;
    logic [MAX_LANES-1:0] w_chk_par;

    assign w_wr_par  = byte_parity(MAX_DATA_W'(w_wdata));
    assign w_chk_par = byte_parity(MAX_DATA_W'(r_rd_data));

    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (w_be[b]) begin
                    r_par[w_addr][b] <= w_wr_par[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_par <= '0;
        end else if (w_rd) begin
            r_rd_par <= w_in_range ? r_par[w_addr] : '0;
        end
    end

    assign w_perr_raw = |(w_chk_par[c_lanes-1:0] ^ r_rd_par);
`else
    assign w_perr_raw = 1'b0;
`endif

    // Issuing port id travels alongside the RAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe_id[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd;
            r_pipe_id[0]  <= w_sel;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
        end
    end

    if (READ_LATENCY > 1) begin : g_out_reg
        logic [DATA_W-1:0] r_out_data;
        logic              r_out_perr;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_out_data <= '0;
                r_out_perr <= 1'b0;
            end else begin
                r_out_data <= r_rd_data;
                r_out_perr <= w_perr_raw;
            end
        end
        assign w_out_data = r_out_data;
        assign w_out_perr = r_out_perr;
    end else begin : g_out_direct
        assign w_out_data = r_rd_data;
        assign w_out_perr = w_perr_raw;
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign readdatavalid[p]              = r_pipe_vld[READ_LATENCY-1] &&
                                               (r_pipe_id[READ_LATENCY-1] == port_id_t'(p));
        assign readdata[p*DATA_W +: DATA_W]  = w_out_data;
        assign parity_err[p]                 = readdatavalid[p] & w_out_perr;
    end

endmodule
`default_nettype wire
